// File: rtl/hex_accumulator.sv
// ---------------------------------------------------------------------------
// hex_accumulator
//
// Front end for the four-digit multiplexed hex display. Each raw push-button
// goes through a 2-FF synchronizer, a debounce FSM and a rising-edge detector.
// The resulting one-cycle pulses drive a 16-bit running sum. The sum and an
// overflow indicator are presented in the form the display multiplexer expects.
//
// Optional feature macro: HEX_ACC_SUB_EN
//   When defined, this adds the btn_sub input and the subtract path.
//   When undefined, the block supports only add and clear.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   sw       in   8  unsigned addend/subtrahend, sampled when the sum updates
//   btn_add  in   1  raw bouncy add button, active-high
//   btn_clr  in   1  raw bouncy clear button, active-high
//   btn_sub  in   1  raw bouncy subtract button (HEX_ACC_SUB_EN only)
//   hex0..3  out  4  sum nibbles, hex0 = sum[3:0] ... hex3 = sum[15:12]
//   dp_in    out  4  active-low decimal points, {~ovf, 3'b111}
//   ovf      out  1  sticky overflow/underflow flag
// ---------------------------------------------------------------------------

// Per-button conditioning: synchronizer, debounce FSM, rising-edge pulse.
module hex_acc_debounce #(
  parameter int DB_TICKS = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DB_TICKS);
  // The counter starts at 0 on entry to a WAIT state.
  // Leaving on this value therefore gives DB_TICKS-1 counting edges.
  localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 2);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  logic [1:0]    sync_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_s;
  logic          level_prev_q;
  logic          pulse_q;
  logic          in_s;

  assign in_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Debounce state and stable-time counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (in_s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end else begin
          state_d = ZERO;
        end
      end
      WAIT1: begin
        if (!in_s) begin
          state_d = ZERO;
        end else if (cnt_q == LAST) begin
          state_d = ONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ONE: begin
        if (!in_s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end else begin
          state_d = ONE;
        end
      end
      WAIT0: begin
        if (in_s) begin
          state_d = ONE;
        end else if (cnt_q == LAST) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_s = (state_q == ONE) || (state_q == WAIT0);

  // Registered rising-edge detector on the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      level_prev_q <= level_s;
      pulse_q      <= level_s & ~level_prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

module hex_accumulator #(
  parameter int DB_TICKS = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_add,
  input  logic       btn_clr,
`ifdef HEX_ACC_SUB_EN
  input  logic       btn_sub,
`endif
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_in,
  output logic       ovf
);

  logic        add_p_s;
  logic        clr_p_s;
  logic [15:0] sum_q, sum_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  dp_q;
  logic [16:0] add_s;

  hex_acc_debounce #(.DB_TICKS(DB_TICKS)) u_db_add (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_add),
    .pulse_o (add_p_s)
  );

  hex_acc_debounce #(.DB_TICKS(DB_TICKS)) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_clr),
    .pulse_o (clr_p_s)
  );

`ifdef HEX_ACC_SUB_EN
  logic        sub_p_s;
  logic [16:0] sub_s;

  hex_acc_debounce #(.DB_TICKS(DB_TICKS)) u_db_sub (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_sub),
    .pulse_o (sub_p_s)
  );
`else
  // No subtract path in this build.
`endif

  // Accumulator next-state logic. Clear has priority.
  // Add together with subtract holds the current sum.
  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    // Bit 16 holds the carry out of the 16-bit add.
    add_s = {1'b0, sum_q} + {9'h000, sw};
`ifdef HEX_ACC_SUB_EN
    // Bit 16 is set on borrow.
    sub_s = {1'b0, sum_q} - {9'h000, sw};
`endif
    if (clr_p_s) begin
      sum_d = 16'h0000;
      ovf_d = 1'b0;
    end
`ifdef HEX_ACC_SUB_EN
    else if (add_p_s && sub_p_s) begin
      sum_d = sum_q;
      ovf_d = ovf_q;
    end else if (sub_p_s) begin
      sum_d = sub_s[15:0];
      ovf_d = ovf_q | sub_s[16];
    end
`endif
    else if (add_p_s) begin
      sum_d = add_s[15:0];
      ovf_d = ovf_q | add_s[16];
    end else begin
      sum_d = sum_q;
      ovf_d = ovf_q;
    end
  end

  // Sum, sticky flag, and decimal-point registers.
  // dp has its own register so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 16'h0000;
      ovf_q <= 1'b0;
      dp_q  <= 4'b1111;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      dp_q  <= {~ovf_d, 3'b111};
    end
  end

  assign hex0  = sum_q[3:0];
  assign hex1  = sum_q[7:4];
  assign hex2  = sum_q[11:8];
  assign hex3  = sum_q[15:12];
  assign dp_in = dp_q;
  assign ovf   = ovf_q;

endmodule
